// File: rtl/turbo_pkg.sv
// Shared types and arithmetic helpers for the LTE-style turbo encoder.
// The RSC step and the modular add are used by the encoder datapath.
package turbo_pkg;

  // Wide enough for the sum of two indices below the largest frame length (2*6143).
  localparam int QW = 14;

  typedef enum logic [1:0] {
    PH_DATA   = 2'd0,
    PH_TERM_U = 2'd1,
    PH_TERM_L = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_TERM_U = 2'd2,
    ST_TERM_L = 2'd3
  } state_t;

  // State is packed as {s1, s2, s3}; returns {next_state, z}.
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic c);
    logic a;
    logic z;
    a = c ^ s[1] ^ s[0];
    z = a ^ s[2] ^ s[0];
    return {a, s[2], s[1], z};
  endfunction

  // Both operands are already reduced, so one conditional subtract suffices.
  function automatic logic [QW-1:0] qpp_add(input logic [QW-1:0] a,
                                            input logic [QW-1:0] b,
                                            input logic [QW-1:0] fl);
    logic [QW-1:0] sum;
    sum = a + b;
    return (sum >= fl) ? (sum - fl) : sum;
  endfunction

endpackage

// File: rtl/turbo_rsc_encoder.sv
// One recursive systematic constituent encoder (8-state LTE trellis).
// In termination mode the input is forced to s2^s3 so the state drains to zero.
module turbo_rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic advance,
  input  logic term,
  input  logic clear,
  output logic z,
  output logic x
);

  logic [2:0] state_q;
  logic       c_eff;
  logic [3:0] step;

  assign c_eff = term ? (state_q[1] ^ state_q[0]) : c;
  assign step  = rsc_step(state_q, c_eff);
  assign z     = step[0];
  assign x     = c_eff;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= 3'b000;
    end else if (advance) begin
      state_q <= step[3:1];
    end
  end

endmodule

// File: rtl/turbo_encoder.sv
// Serial turbo encoder: buffers one frame, then emits FL data beats followed
// by three upper and three lower trellis-termination beats.
//
// Handshake: a beat moves on a rising edge where valid & ready are both high;
// valid never depends on ready, and a stalled beat holds every output stable.
module turbo_encoder
  import turbo_pkg::*;
#(
  parameter int FL = 40,
  parameter int F1 = 3,
  parameter int F2 = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sys,
  output logic       out_par1,
  output logic       out_par2,
  output logic [1:0] out_phase,
  output logic       out_last,
  output logic [1:0] dbg_state
);

  localparam int AW = $clog2(FL + 1);
  localparam logic [AW-1:0] K_FRAME_LAST = AW'(FL - 1);
  localparam logic [AW-1:0] K_TAIL_LAST  = AW'(2);
  localparam logic [AW-1:0] G_INIT       = AW'((F1 + F2) % FL);
  localparam logic [AW-1:0] G_STEP       = AW'((2 * F2) % FL);
  localparam logic [QW-1:0] FL_Q         = QW'(FL);

  state_t         state_q, state_d;
  logic [AW-1:0]  k_q;
  logic [AW-1:0]  pi_q;
  logic [AW-1:0]  g_q;
  logic [FL-1:0]  frame_buf;

  logic load_fire, out_fire, enc_clear;
  logic adv_u, adv_l, term_u, term_l;
  logic z_u, x_u, z_l, x_l;

  assign load_fire = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sys   = 1'b0;
    out_par1  = 1'b0;
    out_par2  = 1'b0;
    out_phase = PH_DATA;
    out_last  = 1'b0;
    adv_u     = 1'b0;
    adv_l     = 1'b0;
    term_u    = 1'b0;
    term_l    = 1'b0;
    enc_clear = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && k_q == K_FRAME_LAST) begin
          state_d   = ST_ENCODE;
          enc_clear = 1'b1;
        end
      end
      ST_ENCODE: begin
        out_valid = 1'b1;
        out_sys   = frame_buf[k_q];
        out_par1  = z_u;
        out_par2  = z_l;
        adv_u     = out_ready;
        adv_l     = out_ready;
        if (out_ready && k_q == K_FRAME_LAST) state_d = ST_TERM_U;
      end
      ST_TERM_U: begin
        out_valid = 1'b1;
        out_phase = PH_TERM_U;
        term_u    = 1'b1;
        out_sys   = x_u;
        out_par1  = z_u;
        adv_u     = out_ready;
        if (out_ready && k_q == K_TAIL_LAST) state_d = ST_TERM_L;
      end
      ST_TERM_L: begin
        out_valid = 1'b1;
        out_phase = PH_TERM_L;
        term_l    = 1'b1;
        out_sys   = x_l;
        out_par2  = z_l;
        out_last  = (k_q == K_TAIL_LAST);
        adv_l     = out_ready;
        if (out_ready && k_q == K_TAIL_LAST) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      k_q     <= '0;
      pi_q    <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD: begin
          if (load_fire) begin
            k_q <= (k_q == K_FRAME_LAST) ? '0 : k_q + AW'(1);
            if (k_q == K_FRAME_LAST) begin
              pi_q <= '0;
              g_q  <= G_INIT;
            end
          end
        end
        ST_ENCODE: begin
          if (out_fire) begin
            k_q  <= (k_q == K_FRAME_LAST) ? '0 : k_q + AW'(1);
            // Second-order difference of the QPP polynomial: no multipliers.
            pi_q <= AW'(qpp_add(QW'(pi_q), QW'(g_q), FL_Q));
            g_q  <= AW'(qpp_add(QW'(g_q), QW'(G_STEP), FL_Q));
          end
        end
        default: begin
          if (out_fire) k_q <= (k_q == K_TAIL_LAST) ? '0 : k_q + AW'(1);
        end
      endcase
    end
  end

  // Buffer contents are don't-care until a full frame has been written.
  always_ff @(posedge clk) begin
    if (load_fire) frame_buf[k_q] <= in_bit;
  end

  turbo_rsc_encoder u_upper (
    .clk     (clk),
    .rst     (rst),
    .c       (frame_buf[k_q]),
    .advance (adv_u),
    .term    (term_u),
    .clear   (enc_clear),
    .z       (z_u),
    .x       (x_u)
  );

  turbo_rsc_encoder u_lower (
    .clk     (clk),
    .rst     (rst),
    .c       (frame_buf[pi_q]),
    .advance (adv_l),
    .term    (term_l),
    .clear   (enc_clear),
    .z       (z_l),
    .x       (x_l)
  );

endmodule

// File: tb/tb_turbo_encoder.sv
// Directed bench for turbo_encoder (FL=40, f1=3, f2=10): frame patterns,
// interleaver positions, backpressure, mid-frame reset and back-to-back frames.
module tb_turbo_encoder;

  localparam int FL = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;
  localparam int NB = FL + 6;
  localparam int W  = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_bit;
  logic       out_valid, out_ready;
  logic       out_sys, out_par1, out_par2, out_last;
  logic [1:0] out_phase, dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_log[NB];
  int           beat_cycles;

  turbo_encoder #(.FL(FL), .F1(F1), .F2(F2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sys   (out_sys),
    .out_par1  (out_par1),
    .out_par2  (out_par2),
    .out_phase (out_phase),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Beat layout: {valid, phase[1:0], sys, par1, par2, last}
  function automatic logic [W-1:0] beat_vec();
    return {out_valid, out_phase, out_sys, out_par1, out_par2, out_last};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: interleaver from the closed-form QPP polynomial.
  task automatic build_expected(input logic [FL-1:0] f);
    logic u1, u2, u3, l1, l2, l3, au, al, zu, zl, x;
    int pi;
    {u1, u2, u3, l1, l2, l3} = '0;
    for (int i = 0; i < FL; i++) begin
      pi = (F1 * i + F2 * i * i) % FL;
      au = f[i] ^ u2 ^ u3;
      zu = au ^ u1 ^ u3;
      al = f[pi] ^ l2 ^ l3;
      zl = al ^ l1 ^ l3;
      exp_q.push_back({1'b1, 2'd0, f[i], zu, zl, 1'b0});
      {u1, u2, u3} = {au, u1, u2};
      {l1, l2, l3} = {al, l1, l2};
    end
    for (int j = 0; j < 3; j++) begin
      x  = u2 ^ u3;
      zu = u1 ^ u3;
      exp_q.push_back({1'b1, 2'd1, x, zu, 1'b0, 1'b0});
      {u1, u2, u3} = {1'b0, u1, u2};
    end
    for (int j = 0; j < 3; j++) begin
      x  = l2 ^ l3;
      zl = l1 ^ l3;
      exp_q.push_back({1'b1, 2'd2, x, 1'b0, zl, j == 2});
      {l1, l2, l3} = {1'b0, l1, l2};
    end
  endtask

  // Starts and ends on a falling edge; each bit moves on the rising edge between.
  task automatic send_bits(input logic [FL-1:0] f, input int n, input bit hold_valid);
    for (int i = 0; i < n; i++) begin
      int budget = 200;
      in_valid = 1'b1;
      in_bit   = f[i];
      while (!in_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) check("in_ready_wait", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = hold_valid;
  endtask

  task automatic collect_frame(input bit rand_ready);
    int b = 0;
    int budget = 2000;
    beat_cycles = 0;
    while (b < NB && budget > 0) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check($sformatf("beat%0d", b), 32'(beat_vec()), 32'(exp_q[0]));
      check("in_ready_low", 32'(in_ready), 32'd0);
      if (out_ready) begin
        obs_log[b] = beat_vec();
        void'(exp_q.pop_front());
        b++;
      end
      @(negedge clk);
      beat_cycles++;
      budget--;
    end
    if (budget == 0) check("beat_timeout", 32'(b), 32'(NB));
    out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_frame(input logic [FL-1:0] f, input bit rand_ready, input bit hold_valid);
    build_expected(f);
    send_bits(f, FL, hold_valid);
    check("first_beat_valid", 32'(out_valid), 32'd1);
    collect_frame(rand_ready);
    exp_q.delete();
  endtask

  function automatic int first_par2_one();
    for (int i = 0; i < FL; i++) if (obs_log[i][1]) return i;
    return -1;
  endfunction

  logic [FL-1:0] frame;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_beat", 32'(beat_vec()), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // All-zero frame, full-rate output
    frame = '0;
    run_frame(frame, 1'b0, 1'b0);
    check("zero_cycles", 32'(beat_cycles), 32'(NB));
    check("zero_first", 32'(obs_log[0]), 32'h40);
    check("zero_last", 32'(obs_log[NB-1]), 32'h61);
    check("zero_beat44", 32'(obs_log[NB-2]), 32'h60);

    // Single 1 at c[0]: upper parity 1,1,1,1 then 0; lower identical since pi(0)=0
    frame = '0;
    frame[0] = 1'b1;
    run_frame(frame, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c0_par1_%0d", i), 32'(obs_log[i][2]), 32'd1);
      check($sformatf("c0_par2_%0d", i), 32'(obs_log[i][1]), 32'd1);
    end
    check("c0_par1_4", 32'(obs_log[4][2]), 32'd0);

    // Interleaver: pi(1)=13, pi(2)=6, pi(3)=19
    frame = '0;
    frame[6] = 1'b1;
    run_frame(frame, 1'b0, 1'b0);
    check("pi2_first", 32'(first_par2_one()), 32'd2);
    frame = '0;
    frame[13] = 1'b1;
    run_frame(frame, 1'b0, 1'b0);
    check("pi1_first", 32'(first_par2_one()), 32'd1);
    frame = '0;
    frame[19] = 1'b1;
    run_frame(frame, 1'b0, 1'b0);
    check("pi3_first", 32'(first_par2_one()), 32'd3);

    // Random frames with random backpressure
    for (int r = 0; r < 3; r++) begin
      frame = FL'({$urandom(), $urandom()});
      run_frame(frame, 1'b1, 1'b0);
    end

    // Reset after 17 inputs, then a fresh frame
    frame = FL'({$urandom(), $urandom()});
    send_bits(frame, 17, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    frame = FL'({$urandom(), $urandom()}) ^ 40'hA5A5A5A5A5;
    run_frame(frame, 1'b0, 1'b0);

    // Back-to-back frames with in_valid held high
    frame = FL'({$urandom(), $urandom()});
    run_frame(frame, 1'b0, 1'b1);
    check("b2b_cycles", 32'(beat_cycles), 32'(NB));
    frame = ~frame;
    run_frame(frame, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
